// File: rtl/dataregister_bank_pkg.sv
// dataregister_bank_pkg: shared command and FSM encodings for the register bank
// and its single-entry shifter.
package dataregister_bank_pkg;

   // Command encodings presented on the op input.
   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SHL  = 2'b01,
      OP_SHR  = 2'b10,
      OP_CLR  = 2'b11
   } op_e;

   // Control FSM states.
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_e;

   // Latched shift direction.
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // True for the two shift commands.
   function automatic logic is_shift_op(input logic [1:0] op_in);
      return (op_in == OP_SHL) || (op_in == OP_SHR);
   endfunction

endpackage

// File: rtl/dataregister_shifter.sv
// dataregister_shifter: combinational next-value unit for one bank entry.
// Produces the value after a single-bit shift in the requested direction,
// with ser_in entering the vacated position, plus the bit pushed out.
module dataregister_shifter
   import dataregister_bank_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] cur_val,
   input  logic                 dir,
   input  logic                 ser_in,
   output logic [DATAWIDTH-1:0] next_val,
   output logic                 shift_out
);

   // Single-bit shift: right drops the LSB, left drops the MSB.
   always_comb begin
      next_val  = cur_val;
      shift_out = 1'b0;
      if (dir == DIR_RIGHT) begin
         next_val  = {ser_in, cur_val[DATAWIDTH-1:1]};
         shift_out = cur_val[0];
      end else begin
         next_val  = {cur_val[DATAWIDTH-2:0], ser_in};
         shift_out = cur_val[DATAWIDTH-1];
      end
   end

endmodule

// File: rtl/dataregister_bank.sv
// dataregister_bank: DEPTH x DATAWIDTH register bank with one command port
// (load / clear / multi-cycle serial shift) and two combinational read ports.
// Optional build macro DATAREGISTER_BANK_WR_BYPASS_EN forwards DataIn to a read
// port whose address matches a LOAD being strobed in IDLE.
module dataregister_bank
   import dataregister_bank_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 4,
   parameter int ADDRWIDTH = 2,
   parameter int CNTWIDTH  = 4
) (
   input  logic                 clk,
   input  logic                 lowRst,
   input  logic                 lowWr,
   input  logic [1:0]           op,
   input  logic [ADDRWIDTH-1:0] wrAddr,
   input  logic [DATAWIDTH-1:0] DataIn,
   input  logic [CNTWIDTH-1:0]  shiftCnt,
   input  logic                 serIn,
   input  logic [ADDRWIDTH-1:0] rdAddrA,
   input  logic [ADDRWIDTH-1:0] rdAddrB,
   output logic [DATAWIDTH-1:0] DataOutA,
   output logic [DATAWIDTH-1:0] DataOutB,
   output logic                 serOut,
   output logic                 busy,
   output logic                 done,
   output logic [DEPTH-1:0]     valid
);

   localparam logic [CNTWIDTH-1:0]  CNT_ZERO  = {CNTWIDTH{1'b0}};
   localparam logic [CNTWIDTH-1:0]  CNT_ONE   = {{(CNTWIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATAWIDTH-1:0] DATA_ZERO = {DATAWIDTH{1'b0}};

   state_e                 state_q, state_d;
   logic [DATAWIDTH-1:0]   mem_q [DEPTH];
   logic [DATAWIDTH-1:0]   mem_d [DEPTH];
   logic [DEPTH-1:0]       valid_q, valid_d;
   logic [CNTWIDTH-1:0]    cnt_q, cnt_d;
   logic [ADDRWIDTH-1:0]   addr_q, addr_d;
   logic                   dir_q, dir_d;
   logic                   serout_q, serout_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [DATAWIDTH-1:0]   shf_next;
   logic                   shf_out;

   // Only the latched entry is ever shifted, so one shifter serves the bank.
   dataregister_shifter #(
      .DATAWIDTH (DATAWIDTH)
   ) u_shifter (
      .cur_val   (mem_q[addr_q]),
      .dir       (dir_q),
      .ser_in    (serIn),
      .next_val  (shf_next),
      .shift_out (shf_out)
   );

   // Command decode, shift sequencing and next-value computation for the bank.
   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      dir_d    = dir_q;
      serout_d = serout_q;
      case (state_q)
         S_IDLE: begin
            if (!lowWr) begin
               case (op)
                  OP_LOAD: begin
                     mem_d[wrAddr]   = DataIn;
                     valid_d[wrAddr] = 1'b1;
                     state_d         = S_DONE;
                  end
                  OP_CLR: begin
                     mem_d[wrAddr]   = DATA_ZERO;
                     valid_d[wrAddr] = 1'b0;
                     state_d         = S_DONE;
                  end
                  OP_SHL, OP_SHR: begin
                     if (shiftCnt == CNT_ZERO) begin
                        // Zero-length shift completes without touching the entry.
                        state_d = S_DONE;
                     end else begin
                        addr_d  = wrAddr;
                        dir_d   = (op == OP_SHR) ? DIR_RIGHT : DIR_LEFT;
                        cnt_d   = shiftCnt;
                        state_d = S_SHIFT;
                     end
                  end
                  default: begin
                     state_d = S_IDLE;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            // Commands arriving here are dropped; only the shift advances.
            mem_d[addr_q] = shf_next;
            serout_d      = shf_out;
            cnt_d         = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
   end

   // State, storage and registered status; reset aborts any shift in flight.
   always_ff @(posedge clk or posedge lowRst) begin
      if (lowRst) begin
         state_q  <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_ZERO;
         end
         valid_q  <= {DEPTH{1'b0}};
         cnt_q    <= CNT_ZERO;
         addr_q   <= {ADDRWIDTH{1'b0}};
         dir_q    <= DIR_LEFT;
         serout_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         dir_q    <= dir_d;
         serout_q <= serout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef DATAREGISTER_BANK_WR_BYPASS_EN
   logic load_now;

   assign load_now = (state_q == S_IDLE) && !lowWr && (op == OP_LOAD);

   // Read ports with same-cycle forwarding of a LOAD being strobed.
   always_comb begin
      if (load_now && (rdAddrA == wrAddr)) begin
         DataOutA = DataIn;
      end else begin
         DataOutA = mem_q[rdAddrA];
      end
      if (load_now && (rdAddrB == wrAddr)) begin
         DataOutB = DataIn;
      end else begin
         DataOutB = mem_q[rdAddrB];
      end
   end
`else
   // Read ports show stored contents only, including mid-shift values.
   always_comb begin
      DataOutA = mem_q[rdAddrA];
      DataOutB = mem_q[rdAddrB];
   end
`endif

   assign serOut = serout_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign valid  = valid_q;

endmodule

// File: tb/tb_dataregister_bank.sv
// tb_dataregister_bank: directed plus randomized checks of dataregister_bank
// against a behavioural array model of the bank.
module tb_dataregister_bank;

   localparam logic [1:0] C_LOAD = 2'b00;
   localparam logic [1:0] C_SHL  = 2'b01;
   localparam logic [1:0] C_SHR  = 2'b10;
   localparam logic [1:0] C_CLR  = 2'b11;

   logic       clk;
   logic       lowRst;
   logic       lowWr;
   logic [1:0] op;
   logic [1:0] wrAddr;
   logic [7:0] DataIn;
   logic [3:0] shiftCnt;
   logic       serIn;
   logic [1:0] rdAddrA;
   logic [1:0] rdAddrB;
   logic [7:0] DataOutA;
   logic [7:0] DataOutB;
   logic       serOut;
   logic       busy;
   logic       done;
   logic [3:0] valid;

   int compared;
   int mismatched;

   // Reference model
   logic [7:0] m_mem [4];
   logic [3:0] m_valid;
   logic       m_ser;

   dataregister_bank dut (
      .clk      (clk),
      .lowRst   (lowRst),
      .lowWr    (lowWr),
      .op       (op),
      .wrAddr   (wrAddr),
      .DataIn   (DataIn),
      .shiftCnt (shiftCnt),
      .serIn    (serIn),
      .rdAddrA  (rdAddrA),
      .rdAddrB  (rdAddrB),
      .DataOutA (DataOutA),
      .DataOutB (DataOutB),
      .serOut   (serOut),
      .busy     (busy),
      .done     (done),
      .valid    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
      m_valid = 4'b0000;
      m_ser   = 1'b0;
   endtask

   // Compare read ports (A at addr, B at a random entry), valid and serOut.
   task automatic check_state(input string tag, input logic [1:0] addr);
      logic [1:0] b;
      b = 2'($urandom_range(0, 3));
      rdAddrA = addr;
      rdAddrB = b;
      #1;
      chk({tag, "_rdA"}, {24'd0, DataOutA}, {24'd0, m_mem[addr]});
      chk({tag, "_rdB"}, {24'd0, DataOutB}, {24'd0, m_mem[b]});
      chk({tag, "_valid"}, {28'd0, valid}, {28'd0, m_valid});
      chk({tag, "_serOut"}, {31'd0, serOut}, {31'd0, m_ser});
   endtask

   task automatic do_load_clr(input logic [1:0] cmd, input logic [1:0] addr, input logic [7:0] data);
      logic [7:0] exp_strobe;
      lowWr   = 1'b0;
      op      = cmd;
      wrAddr  = addr;
      DataIn  = data;
      rdAddrA = addr;
      rdAddrB = addr;
      #1;
      exp_strobe = m_mem[addr];
`ifdef DATAREGISTER_BANK_WR_BYPASS_EN
      if (cmd == C_LOAD) exp_strobe = data;
`endif
      chk("strobe_rdA", {24'd0, DataOutA}, {24'd0, exp_strobe});
      chk("strobe_rdB", {24'd0, DataOutB}, {24'd0, exp_strobe});
      tick();
      lowWr = 1'b1;
      if (cmd == C_LOAD) begin
         m_mem[addr]   = data;
         m_valid[addr] = 1'b1;
      end else begin
         m_mem[addr]   = 8'h00;
         m_valid[addr] = 1'b0;
      end
      chk("wr_done", {31'd0, done}, 32'd1);
      chk("wr_busy", {31'd0, busy}, 32'd0);
      check_state("wr", addr);
      tick();
      chk("wr_done_drop", {31'd0, done}, 32'd0);
   endtask

   // ser_fixed < 0 selects a random serial bit per shift.
   task automatic do_shift(input logic [1:0] cmd, input logic [1:0] addr, input int cnt,
                           input int ser_fixed, input bit intrude);
      int v;
      lowWr    = 1'b0;
      op       = cmd;
      wrAddr   = addr;
      shiftCnt = 4'(cnt);
      serIn    = 1'($urandom);
      tick();
      lowWr = 1'b1;
      if (cnt == 0) begin
         chk("sh0_done", {31'd0, done}, 32'd1);
         chk("sh0_busy", {31'd0, busy}, 32'd0);
         check_state("sh0", addr);
         tick();
         chk("sh0_done_drop", {31'd0, done}, 32'd0);
         chk("sh0_busy_after", {31'd0, busy}, 32'd0);
      end else begin
         chk("sh_start_busy", {31'd0, busy}, 32'd1);
         chk("sh_start_done", {31'd0, done}, 32'd0);
         check_state("sh_start", addr);
         for (int k = 1; k <= cnt; k++) begin
            serIn = (ser_fixed < 0) ? 1'($urandom) : 1'(ser_fixed);
            if (intrude && k == 1) begin
               lowWr  = 1'b0;
               op     = C_LOAD;
               wrAddr = addr + 2'd1;
               DataIn = 8'($urandom);
            end
            tick();
            lowWr = 1'b1;
            v = int'(m_mem[addr]);
            if (cmd == C_SHL) begin
               m_ser = 1'((v >> 7) & 1);
               v     = ((v << 1) | int'(serIn)) & 255;
            end else begin
               m_ser = 1'(v & 1);
               v     = (v >> 1) | (int'(serIn) << 7);
            end
            m_mem[addr] = 8'(v);
            chk("sh_busy", {31'd0, busy}, {31'd0, (k < cnt)});
            chk("sh_done", {31'd0, done}, {31'd0, (k == cnt)});
            check_state("sh_step", addr);
         end
         tick();
         chk("sh_end_done", {31'd0, done}, 32'd0);
         chk("sh_end_busy", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      lowRst   = 1'b1;
      lowWr    = 1'b1;
      op       = C_LOAD;
      wrAddr   = 2'd0;
      DataIn   = 8'h00;
      shiftCnt = 4'd0;
      serIn    = 1'b0;
      rdAddrA  = 2'd0;
      rdAddrB  = 2'd0;
      model_reset();
      tick();
      tick();
      lowRst = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      check_state("rst", 2'd3);

      // LOAD 0xA5 to entry 2
      do_load_clr(C_LOAD, 2'd2, 8'hA5);
      chk("load_valid_const", {28'd0, valid}, 32'h4);

      // SHL x3 with serIn=1 on 0x81
      do_load_clr(C_LOAD, 2'd1, 8'h81);
      do_shift(C_SHL, 2'd1, 3, 1, 1'b0);
      rdAddrA = 2'd1;
      #1;
      chk("shl3_const", {24'd0, DataOutA}, 32'h0F);
      chk("shl3_ser_const", {31'd0, serOut}, 32'd0);

      // SHR x2 with serIn=0 on 0x81, with a LOAD to entry 3 during busy
      do_load_clr(C_LOAD, 2'd0, 8'h81);
      do_shift(C_SHR, 2'd0, 2, 0, 1'b0);
      rdAddrA = 2'd0;
      #1;
      chk("shr2_const", {24'd0, DataOutA}, 32'h20);
      lowWr    = 1'b0;
      op       = C_SHR;
      wrAddr   = 2'd2;
      shiftCnt = 4'd2;
      tick();
      lowWr  = 1'b0;
      op     = C_LOAD;
      wrAddr = 2'd3;
      DataIn = 8'hEE;
      tick();
      lowWr = 1'b1;
      m_ser = m_mem[2][0];
      m_mem[2] = {serIn, m_mem[2][7:1]};
      check_state("intrude", 2'd3);
      tick();
      m_ser = m_mem[2][0];
      m_mem[2] = {serIn, m_mem[2][7:1]};
      chk("intrude_done", {31'd0, done}, 32'd1);
      check_state("intrude_end", 2'd2);
      tick();
      chk("intrude_valid3", {31'd0, valid[3]}, 32'd0);

      // Reset after 2 of 5 shifts
      lowWr    = 1'b0;
      op       = C_SHL;
      wrAddr   = 2'd1;
      shiftCnt = 4'd5;
      tick();
      lowWr = 1'b1;
      tick();
      tick();
      lowRst = 1'b1;
      #1;
      model_reset();
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 4; i++) check_state("mrst", 2'(i));
      tick();
      lowRst = 1'b0;
      tick();
      chk("mrst_no_done", {31'd0, done}, 32'd0);
      chk("mrst_no_busy", {31'd0, busy}, 32'd0);
      do_load_clr(C_LOAD, 2'd3, 8'h3C);

      // Zero-count shift, then CLR
      do_shift(C_SHL, 2'd3, 0, -1, 1'b0);
      do_load_clr(C_CLR, 2'd3, 8'h00);
      chk("clr_valid3", {31'd0, valid[3]}, 32'd0);

      // Same-cycle read of a LOAD on both ports
      do_load_clr(C_LOAD, 2'd1, 8'h11);
      do_load_clr(C_LOAD, 2'd1, 8'h5A);

      // Randomized commands
      for (int n = 0; n < 40; n++) begin
         logic [1:0] c;
         logic [1:0] a;
         c = 2'($urandom_range(0, 3));
         a = 2'($urandom_range(0, 3));
         if (c == C_LOAD || c == C_CLR) begin
            do_load_clr(c, a, 8'($urandom));
         end else begin
            do_shift(c, a, $urandom_range(0, 11), -1, 1'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
